lif_neuron_array: RTL and testbench

Parametrised array of leaky integrate-and-fire neurons, the successor to the single non-leaky IF neuron. It supports N independent channels of configurable width, shift-based leak, a refractory period, and a runtime-selectable reset mode. All channels share one threshold and one mode, and integrate every enabled clock. It sits directly behind the chip's input pins: per-channel input current comes in, and registered membrane state plus one-cycle spike pulses go out to the output and bidirectional pins.

---
 rtl/lif_pkg.sv | 35 +++
 rtl/lif_cell.sv | 72 +++++++
 rtl/lif_neuron_array.sv | 75 +++++++
 tb/tb_lif_neuron_array.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants and helpers for the leaky integrate-and-fire neuron array.
package lif_pkg;

    // Default array configuration.
    localparam int DEF_N_NEURONS  = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_LEAK_SHIFT = 1;
    localparam int DEF_REF_CYCLES = 2;

    // Working width of the saturating adder; WIDTH must stay below this.
    localparam int SAT_W = 32;

    // Post-spike reset modes.
    localparam logic RST_ZERO = 1'b0;
    localparam logic RST_SUB  = 1'b1;

    // Refractory counter width: enough to hold REF_CYCLES, never less than one bit.
    function automatic int ref_width(input int ref_cycles);
        return (ref_cycles <= 0) ? 1 : $clog2(ref_cycles + 1);
    endfunction

    // Unsigned add of two width-bit operands, clamped to 2^width - 1.
    function automatic logic [SAT_W-1:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      width
    );
        logic [SAT_W:0] sum;
        logic [SAT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((SAT_W+1)'(1) << width) - (SAT_W+1)'(1);
        return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One leaky integrate-and-fire channel: membrane state, refractory counter,
// spike register, shift leak, saturating integrate and threshold compare.
module lif_cell
    import lif_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] current,
    input  logic [WIDTH-1:0] threshold,
    input  logic             reset_mode,
    input  logic             leak_en,
    output logic [WIDTH-1:0] state,
    output logic             spike,
    output logic             spike_next
);

    localparam int RW = ref_width(REF_CYCLES);
    localparam logic [RW-1:0] REF_LOAD = RW'(REF_CYCLES);

    logic [WIDTH-1:0] state_q, state_d;
    logic [RW-1:0]    ref_cnt_q, ref_cnt_d;
    logic             spike_q, spike_d;
    logic [WIDTH-1:0] leaked;
    logic [WIDTH-1:0] sum;

    // Next-state: refractory bypass, otherwise integrate and test for a spike.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        ref_cnt_d = ref_cnt_q;
        spike_d   = 1'b0;
        leaked    = leak_en ? (state_q - (state_q >> LEAK_SHIFT)) : state_q;
        sum       = WIDTH'(sat_add(SAT_W'(leaked), SAT_W'(current), WIDTH));
        if (en) begin
            if (ref_cnt_q != '0) begin
                // Refractory: input is ignored, only the leak acts.
                state_d   = leaked;
                ref_cnt_d = ref_cnt_q - RW'(1);
            end else if (sum >= threshold) begin
                spike_d   = 1'b1;
                ref_cnt_d = REF_LOAD;
                state_d   = (reset_mode == RST_SUB) ? (sum - threshold) : '0;
            end else begin
                state_d = sum;
            end
        end
    end

    // Channel registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q   <= '0;
            ref_cnt_q <= '0;
            spike_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            spike_q   <= spike_d;
        end
    end

    assign state      = state_q;
    assign spike      = spike_q;
    assign spike_next = spike_d;

endmodule

// File: rtl/lif_neuron_array.sv
// Array of independent LIF channels sharing threshold, reset mode and leak
// control, with a registered any-spike flag and a local reset synchroniser.
module lif_neuron_array
    import lif_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REF_CYCLES = DEF_REF_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_NEURONS*WIDTH-1:0] current,
    input  logic [WIDTH-1:0]           threshold,
    input  logic                       reset_mode,
    input  logic                       leak_en,
    output logic [N_NEURONS*WIDTH-1:0] state,
    output logic [N_NEURONS-1:0]       spike,
    output logic                       any_spike
);

    logic [1:0]           rst_sync_q, rst_sync_d;
    logic                 rst_n_int;
    logic [N_NEURONS-1:0] spike_next;
    logic                 any_spike_q, any_spike_d;

    // Shift register inputs: ones march in after the pin releases.
    always_comb begin
        rst_sync_d  = {rst_sync_q[0], 1'b1};
        any_spike_d = |spike_next;
    end

    // Reset synchroniser: assertion is immediate, release is aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_n_int = rst_sync_q[1];

    for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
        lif_cell #(
            .WIDTH      (WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT),
            .REF_CYCLES (REF_CYCLES)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n_int),
            .en         (en),
            .current    (current[g*WIDTH +: WIDTH]),
            .threshold  (threshold),
            .reset_mode (reset_mode),
            .leak_en    (leak_en),
            .state      (state[g*WIDTH +: WIDTH]),
            .spike      (spike[g]),
            .spike_next (spike_next[g])
        );
    end

    // any_spike registered alongside the per-channel spike bits.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            any_spike_q <= 1'b0;
        end else begin
            any_spike_q <= any_spike_d;
        end
    end

    assign any_spike = any_spike_q;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array: directed scenarios followed by a
// randomized run, all compared against an arithmetic reference model.
module tb_lif_neuron_array;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LS  = 1;
    localparam int REF = 2;
    localparam int MAXV = (1 << W) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N*W-1:0] current;
    logic [W-1:0]   threshold;
    logic           reset_mode;
    logic           leak_en;
    logic [N*W-1:0] state;
    logic [N-1:0]   spike;
    logic           any_spike;

    int tests = 0;
    int fails = 0;

    // Stimulus per channel and reference-model state.
    int cur   [N];
    int m_st  [N];
    int m_ref [N];
    int m_spk [N];
    int m_any;

    lif_neuron_array #(
        .N_NEURONS  (N),
        .WIDTH      (W),
        .LEAK_SHIFT (LS),
        .REF_CYCLES (REF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .current    (current),
        .threshold  (threshold),
        .reset_mode (reset_mode),
        .leak_en    (leak_en),
        .state      (state),
        .spike      (spike),
        .any_spike  (any_spike)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dut_state(input int ch);
        return int'(state[ch*W +: W]);
    endfunction

    // Reference model: one enabled or disabled cycle, straight from the rules.
    task automatic model_cycle();
        int leaked, total;
        m_any = 0;
        for (int i = 0; i < N; i++) begin
            m_spk[i] = 0;
            if (!en) continue;
            leaked = leak_en ? m_st[i] - m_st[i] / (2 ** LS) : m_st[i];
            total  = leaked + cur[i];
            if (total > MAXV) total = MAXV;
            if (m_ref[i] > 0) begin
                m_st[i]  = leaked;
                m_ref[i] = m_ref[i] - 1;
            end else if (total >= int'(threshold)) begin
                m_spk[i] = 1;
                m_ref[i] = REF;
                m_st[i]  = reset_mode ? total - int'(threshold) : 0;
            end else begin
                m_st[i] = total;
            end
            if (m_spk[i] != 0) m_any = 1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s c%0d state", tag, i), 32'(dut_state(i)), 32'(m_st[i]));
            check($sformatf("%s c%0d spike", tag, i), 32'(spike[i]), 32'(m_spk[i]));
        end
        check($sformatf("%s any_spike", tag), 32'(any_spike), 32'(m_any));
    endtask

    // Apply the current stimulus for one clock edge and compare after it.
    task automatic step(input string tag);
        for (int i = 0; i < N; i++) current[i*W +: W] = W'(cur[i]);
        model_cycle();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
        cur[0] = c0; cur[1] = c1; cur[2] = c2; cur[3] = c3;
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_ref[i] = 0; m_spk[i] = 0;
        end
        m_any = 0;
    endtask

    // Full reset: assert, check the immediate clear, release and let it settle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        en    = 1'b0;
        set_cur(0, 0, 0, 0);
        current = '0;
        clear_model();
        #1;
        check_all({tag, " rst"});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all({tag, " post-rst"});
    endtask

    initial begin
        rst_n      = 1'b1;
        en         = 1'b0;
        current    = '0;
        threshold  = 8'd200;
        reset_mode = 1'b0;
        leak_en    = 1'b0;
        set_cur(0, 0, 0, 0);
        #2;
        do_reset("init");

        // Asynchronous reset mid-cycle with ch0 at 150.
        en = 1'b1; leak_en = 1'b0; reset_mode = 1'b0; threshold = 8'd200;
        set_cur(50, 0, 0, 0);
        repeat (3) step("pre-rst");
        check("async pre state", 32'(dut_state(0)), 32'd150);
        #3 rst_n = 1'b0;
        #1;
        check("async state", 32'(dut_state(0)), 32'd0);
        check("async spike", 32'(spike), 32'd0);
        check("async any", 32'(any_spike), 32'd0);
        do_reset("async");

        // Integrate-and-fire, reset to zero, then refractory.
        en = 1'b1; leak_en = 1'b0; reset_mode = 1'b0; threshold = 8'd200;
        set_cur(50, 0, 0, 0);
        step("if e1"); check("if e1 st", 32'(dut_state(0)), 32'd50);
        step("if e2"); check("if e2 st", 32'(dut_state(0)), 32'd100);
        step("if e3"); check("if e3 st", 32'(dut_state(0)), 32'd150);
        step("if e4"); check("if e4 st", 32'(dut_state(0)), 32'd0);
        check("if e4 spk", 32'(spike[0]), 32'd1);
        step("if e5"); check("if e5 st", 32'(dut_state(0)), 32'd0);
        check("if e5 spk", 32'(spike[0]), 32'd0);
        step("if e6"); check("if e6 st", 32'(dut_state(0)), 32'd0);
        step("if e7"); check("if e7 st", 32'(dut_state(0)), 32'd50);

        // Subtract reset with saturation.
        do_reset("sub");
        en = 1'b1; leak_en = 1'b0; reset_mode = 1'b1; threshold = 8'd250;
        set_cur(200, 0, 0, 0);
        step("sub e1"); check("sub e1 st", 32'(dut_state(0)), 32'd200);
        step("sub e2"); check("sub e2 st", 32'(dut_state(0)), 32'd5);
        check("sub e2 spk", 32'(spike[0]), 32'd1);

        // Leak decay to the truncation floor.
        do_reset("leak");
        begin
            int exp_leak [9] = '{100, 50, 25, 13, 7, 4, 2, 1, 1};
            en = 1'b1; leak_en = 1'b1; reset_mode = 1'b0; threshold = 8'd255;
            for (int k = 0; k < 9; k++) begin
                set_cur((k == 0) ? 100 : 0, 0, 0, 0);
                step("leak");
                check($sformatf("leak e%0d st", k + 1), 32'(dut_state(0)), 32'(exp_leak[k]));
            end
        end

        // Enable hold on ch1.
        do_reset("hold");
        en = 1'b1; leak_en = 1'b0; reset_mode = 1'b0; threshold = 8'd200;
        set_cur(0, 50, 0, 0);
        repeat (3) step("hold int");
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("hold off");
            check("hold st", 32'(dut_state(1)), 32'd150);
            check("hold spk", 32'(spike[1]), 32'd0);
        end
        en = 1'b1;
        step("hold fire");
        check("hold fire spk", 32'(spike[1]), 32'd1);
        check("hold fire any", 32'(any_spike), 32'd1);

        // Channel independence: only ch0 spikes, every third cycle.
        do_reset("indep");
        en = 1'b1; leak_en = 1'b0; reset_mode = 1'b0; threshold = 8'd100;
        set_cur(255, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            step("indep");
            check($sformatf("indep e%0d spk", k), 32'(spike), (k % 3 == 1) ? 32'd1 : 32'd0);
            check($sformatf("indep e%0d any", k), 32'(any_spike), (k % 3 == 1) ? 32'd1 : 32'd0);
            check($sformatf("indep e%0d c3", k), 32'(dut_state(3)), 32'd0);
        end

        // Threshold zero: fires whenever not refractory, no lock-up.
        threshold = 8'd0;
        set_cur(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step("thr0");

        // Randomized run with all controls varying.
        for (int k = 0; k < 300; k++) begin
            en         = ($urandom_range(0, 7) != 0);
            leak_en    = 1'($urandom_range(0, 1));
            reset_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) threshold = 8'($urandom_range(0, 255));
            else if (k == 0) threshold = 8'd120;
            for (int i = 0; i < N; i++) cur[i] = $urandom_range(0, 255) >> $urandom_range(0, 4);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
